uart_tx_ctrl: RTL and testbench

- Sequencing controller for the UART transmit path: accepts a byte on a start handshake and pulses Load_data into the parity generator.
- Serialises the frame: start bit, 8 data bits LSB-first, optional parity bit, STOP_BITS stop bits, with a baud-rate counter.
- Sits between the host-side byte interface and the Tx_serial line, alongside the parity generator.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_cnt.sv | 28 ++
 rtl/uart_tx_ctrl.sv | 119 +++++++++++
 tb/tb_uart_tx_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line levels and default bit timing.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam int   DATA_BITS            = 8;
  localparam logic IDLE_LEVEL           = 1'b1;
  localparam logic START_LEVEL          = 1'b0;
  localparam int   DEFAULT_CLKS_PER_BIT = 868;
  // Wide enough for the full legal CLKS_PER_BIT range (up to 65535).
  localparam int   BAUD_CNT_W           = 16;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_tick
);

  logic [BAUD_CNT_W-1:0] cnt_reg;

  assign bit_tick = (cnt_reg == BAUD_CNT_W'(CLKS_PER_BIT - 1));

  // Wrapping on bit_tick restarts the count at every bit boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clear || bit_tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start bit, 8 data bits LSB-first, optional parity, stop bits.
// Define UART_TX_PARITY_EN to insert the parity bit taken from the Parity input.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Tx_start,
  input  logic [7:0] Tx_data,
  input  logic       Parity,
  output logic       Load_data,
  output logic       Tx_serial,
  output logic       Tx_busy,
  output logic       Tx_done
);

  tx_state_t              state_reg;
  logic [DATA_BITS-1:0]   shift_reg;
  logic [2:0]             bit_idx_reg;
  logic                   bit_tick;
  logic                   baud_clear;

`ifndef UART_TX_PARITY_EN
  logic unused_parity;
  assign unused_parity = Parity;
`endif

  // Holding the counter cleared while idle makes the start bit begin at count 0.
  assign baud_clear = (state_reg == ST_IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (baud_clear),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= '0;
      bit_idx_reg <= '0;
      Tx_serial   <= IDLE_LEVEL;
      Tx_busy     <= 1'b0;
      Tx_done     <= 1'b0;
      Load_data   <= 1'b0;
    end else begin
      Load_data <= 1'b0;
      Tx_done   <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (Tx_start) begin
            shift_reg   <= Tx_data;
            Load_data   <= 1'b1;
            Tx_serial   <= START_LEVEL;
            Tx_busy     <= 1'b1;
            bit_idx_reg <= '0;
            state_reg   <= ST_START;
          end
        end
        ST_START: begin
          if (bit_tick) begin
            Tx_serial   <= shift_reg[0];
            shift_reg   <= shift_reg >> 1;
            bit_idx_reg <= '0;
            state_reg   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            if (bit_idx_reg == 3'(DATA_BITS - 1)) begin
              bit_idx_reg <= '0;
`ifdef UART_TX_PARITY_EN
              Tx_serial   <= Parity;
              state_reg   <= ST_PARITY;
`else
              Tx_serial   <= IDLE_LEVEL;
              state_reg   <= ST_STOP;
`endif
            end else begin
              Tx_serial   <= shift_reg[0];
              shift_reg   <= shift_reg >> 1;
              bit_idx_reg <= bit_idx_reg + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_tick) begin
            Tx_serial   <= IDLE_LEVEL;
            bit_idx_reg <= '0;
            state_reg   <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          // bit_idx_reg is reused here to count stop bits.
          if (bit_tick) begin
            if (bit_idx_reg == 3'(STOP_BITS - 1)) begin
              bit_idx_reg <= '0;
              Tx_busy     <= 1'b0;
              Tx_done     <= 1'b1;
              state_reg   <= ST_IDLE;
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl with CLKS_PER_BIT=4; covers both UART_TX_PARITY_EN builds.
module tb_uart_tx_ctrl;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
  localparam int SB  = 1;
`else
  localparam int PAR = 0;
  localparam int SB  = 2;
`endif
  localparam int CPB       = 4;
  localparam int NSLOT     = 9 + PAR + SB;
  localparam int FRAME_CYC = 44;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       Tx_start = 1'b0;
  logic [7:0] Tx_data  = 8'h00;
  logic       Parity;
  logic       Load_data, Tx_serial, Tx_busy, Tx_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  uart_tx_ctrl #(
    .CLKS_PER_BIT (CPB),
    .STOP_BITS    (SB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Tx_start  (Tx_start),
    .Tx_data   (Tx_data),
    .Parity    (Parity),
    .Load_data (Load_data),
    .Tx_serial (Tx_serial),
    .Tx_busy   (Tx_busy),
    .Tx_done   (Tx_done)
  );

  always #5 clk = ~clk;

  // Stand-in parity generator: latches the even parity of Tx_data when loaded.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) Parity <= 1'b0;
    else if (Load_data) Parity <= ^Tx_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame model: level of slot s of a frame carrying byte b.
  function automatic logic slot_level(input logic [7:0] b, input int s);
    if (s == 0) return 1'b0;
    if (s <= 8) return b[s-1];
    if (PAR == 1 && s == 9) return ^b;
    return 1'b1;
  endfunction

  bit         m_active = 1'b0;
  int         m_k      = 0;
  logic [7:0] m_byte   = 8'h00;
  logic       e_serial = 1'b1, e_busy = 1'b0, e_done = 1'b0, e_load = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0; m_k = 0;
      e_serial = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_load = 1'b0;
    end else begin
      cyc++;
      e_done = 1'b0;
      e_load = 1'b0;
      if (m_active) begin
        m_k++;
        if (m_k == NSLOT * CPB) begin
          m_active = 1'b0; e_done = 1'b1; e_busy = 1'b0; e_serial = 1'b1;
        end else begin
          e_serial = slot_level(m_byte, m_k / CPB);
        end
      end else if (Tx_start) begin
        m_active = 1'b1; m_k = 0; m_byte = Tx_data;
        e_serial = 1'b0; e_busy = 1'b1; e_load = 1'b1;
      end
    end
  end

  logic [10:0] trace = '0;
  int          t_load = 0;
  int          load_count = 0;

  always @(negedge clk) begin
    chk("tx_serial", 32'(Tx_serial), 32'(e_serial));
    chk("tx_busy",   32'(Tx_busy),   32'(e_busy));
    chk("tx_done",   32'(Tx_done),   32'(e_done));
    chk("load_data", 32'(Load_data), 32'(e_load));
    if (Load_data) begin
      t_load = cyc;
      load_count++;
      trace = '0;
    end
    if (m_active && (m_k % CPB) == 2) trace[m_k / CPB] = Tx_serial;
    if (Tx_done) chk("frame_len", 32'(cyc - t_load), 32'(FRAME_CYC));
  end

  task automatic send(input logic [7:0] d);
    Tx_data  = d;
    Tx_start = 1'b1;
    @(negedge clk);
    Tx_start = 1'b0;
    @(negedge clk);
    Tx_data  = ~d;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (Tx_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_timeout"}, 32'(n < 200), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int lc0;
    int n;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_serial", 32'(Tx_serial), 32'd1);
    chk("rst_busy",   32'(Tx_busy),   32'd0);
    chk("rst_done",   32'(Tx_done),   32'd0);
    chk("rst_load",   32'(Load_data), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send(8'hA5);
    wait_idle("a5");
`ifdef UART_TX_PARITY_EN
    chk("trace_a5", 32'(trace), 32'(11'b10101001010));
`else
    chk("trace_a5", 32'(trace), 32'(11'b11101001010));
`endif

    send(8'h07);
    wait_idle("x07");
    chk("trace_07", 32'(trace), 32'(11'b11000001110));

    send(8'h00);
    wait_idle("x00");
`ifdef UART_TX_PARITY_EN
    chk("trace_00", 32'(trace), 32'(11'b10000000000));
`else
    chk("trace_00", 32'(trace), 32'(11'b11000000000));
`endif

    // Start request mid-frame must be ignored.
    lc0 = load_count;
    send(8'h81);
    repeat (8) @(negedge clk);
    Tx_data  = 8'hFF;
    Tx_start = 1'b1;
    @(negedge clk);
    Tx_start = 1'b0;
    Tx_data  = 8'h00;
    wait_idle("busy_rej");
`ifdef UART_TX_PARITY_EN
    chk("trace_81", 32'(trace), 32'(11'b10100000010));
`else
    chk("trace_81", 32'(trace), 32'(11'b11100000010));
`endif
    repeat (20) @(negedge clk);
    chk("reject_loads", 32'(load_count - lc0), 32'd1);

    // Back-to-back frames with Tx_start held high.
    Tx_data  = 8'h55;
    Tx_start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    Tx_data = 8'hAA;
    n = 0;
    while (!Tx_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done_timeout", 32'(n < 100), 32'd1);
    chk("b2b_gap_busy", 32'(Tx_busy), 32'd0);
`ifdef UART_TX_PARITY_EN
    chk("trace_55", 32'(trace), 32'(11'b10010101010));
`else
    chk("trace_55", 32'(trace), 32'(11'b11010101010));
`endif
    @(negedge clk);
    chk("b2b_start_bit", 32'(Tx_serial), 32'd0);
    chk("b2b_busy", 32'(Tx_busy), 32'd1);
    Tx_start = 1'b0;
    wait_idle("b2b");
`ifdef UART_TX_PARITY_EN
    chk("trace_aa", 32'(trace), 32'(11'b10101010100));
`else
    chk("trace_aa", 32'(trace), 32'(11'b11101010100));
`endif

    // Reset during data bit 3 aborts the frame asynchronously.
    send(8'hC3);
    n = 0;
    while (!(m_active && m_k == 17) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("abort_wait_timeout", 32'(n < 100), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_serial", 32'(Tx_serial), 32'd1);
    chk("abort_busy",   32'(Tx_busy),   32'd0);
    chk("abort_done",   32'(Tx_done),   32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h3C);
    wait_idle("x3c");
`ifdef UART_TX_PARITY_EN
    chk("trace_3c", 32'(trace), 32'(11'b10001111000));
`else
    chk("trace_3c", 32'(trace), 32'(11'b11001111000));
`endif

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
